beam_sum_sequencer: RTL and testbench

BEAM_SUM_SEQUENCER -- requirements
Module: beam_sum_sequencer

---
 rtl/beam_sum_sequencer_pkg.sv | 36 +++
 rtl/beam_sum_sequencer_read_tag_pipe.sv | 43 ++++
 rtl/beam_sum_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_beam_sum_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_sum_sequencer_pkg.sv
// Shared constants and types for the beam summing sequencer.
// Sizes, the FSM state encoding and the read-tag record are kept here
// so that the filter and indexing controllers can reuse them.
package beam_sum_sequencer_pkg;

   localparam int NUM_CH  = 8;    // channels summed per output sample
   localparam int SEG_LEN = 768;  // samples per channel segment
   localparam int DATA_W  = 32;   // input sample width
   localparam int SUM_W   = 40;   // sum width
   localparam int RD_LAT  = 1;    // output-RAM read latency in cycles

   localparam int CH_W   = $clog2(NUM_CH);
   localparam int T_W    = $clog2(SEG_LEN);
   localparam int ADDR_W = $clog2(NUM_CH * SEG_LEN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Sideband carried alongside every issued read.
   typedef struct packed {
      logic           vld;
      logic           first;
      logic           last;
      logic [T_W-1:0] t;
   } rd_tag_t;

   // Sign-extend one two's-complement sample to the sum width.
   function automatic logic [SUM_W-1:0] sext_sample(input logic [DATA_W-1:0] d);
      return {{(SUM_W-DATA_W){d[DATA_W-1]}}, d};
   endfunction

endpackage

// File: rtl/beam_sum_sequencer_read_tag_pipe.sv
// read_tag_pipe: RD_LAT-deep delay line for read tags, so that each tag
// arrives in the same cycle as the RAM data it describes.
// Ports:
//   clk, reset (async, active low)
//   flush            synchronous clear of every stage (used by abort)
//   in_vld/in_first/in_last/in_t     tag of the read visible this cycle
//   out_vld/out_first/out_last/out_t tag aligned with the read data
module read_tag_pipe
   import beam_sum_sequencer_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           in_vld,
   input  logic           in_first,
   input  logic           in_last,
   input  logic [T_W-1:0] in_t,
   output logic           out_vld,
   output logic           out_first,
   output logic           out_last,
   output logic [T_W-1:0] out_t
);

   rd_tag_t stage_r [RD_LAT];

   // Shift register of tags; flush empties every stage at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RD_LAT; i++) stage_r[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < RD_LAT; i++) stage_r[i] <= '0;
      end else begin
         stage_r[0] <= '{vld: in_vld, first: in_first, last: in_last, t: in_t};
         for (int i = 1; i < RD_LAT; i++) stage_r[i] <= stage_r[i-1];
      end
   end

   assign out_vld   = stage_r[RD_LAT-1].vld;
   assign out_first = stage_r[RD_LAT-1].first;
   assign out_last  = stage_r[RD_LAT-1].last;
   assign out_t     = stage_r[RD_LAT-1].t;

endmodule

// File: rtl/beam_sum_sequencer.sv
// beam_sum_sequencer: for each t in 0..SEG_LEN-1 reads the sample of every
// channel from the output RAM (channel-major address ch*SEG_LEN+t), sums
// them sign-extended, and writes the sum to sum-RAM address t.
// Ports:
//   clk, reset (async, active low)
//   start / pause / abort            pass control
//   busy / done                      pass status (registered)
//   out_rd_en/out_rd_addr/out_rd_data  output-RAM read port
//   sum_wr_en/sum_wr_addr/sum_wr_data  sum-RAM write port (registered)
module beam_sum_sequencer
   import beam_sum_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              out_rd_en,
   output logic [ADDR_W-1:0] out_rd_addr,
   input  logic [DATA_W-1:0] out_rd_data,
   output logic              sum_wr_en,
   output logic [T_W-1:0]    sum_wr_addr,
   output logic [SUM_W-1:0]  sum_wr_data
);

   state_t             state_r, next_state_s;
   logic               issue_s, abort_act_s, final_wr_s;
   logic [CH_W-1:0]    ch_r;
   logic [T_W-1:0]     t_r;
   logic [ADDR_W-1:0]  rd_addr_s;
   logic               busy_r, done_r;
   logic               out_rd_en_r;
   logic [ADDR_W-1:0]  out_rd_addr_r;
   logic               iss_first_r, iss_last_r;
   logic [T_W-1:0]     iss_t_r;
   logic               tag_vld_s, tag_first_s, tag_last_s;
   logic [T_W-1:0]     tag_t_s;
   logic [SUM_W-1:0]   acc_r, acc_next_s;
   logic               sum_wr_en_r;
   logic [T_W-1:0]     sum_wr_addr_r;
   logic [SUM_W-1:0]   sum_wr_data_r;

   assign rd_addr_s  = ADDR_W'(ch_r) * ADDR_W'(SEG_LEN) + ADDR_W'(t_r);
   assign final_wr_s = tag_vld_s && tag_last_s && (tag_t_s == T_W'(SEG_LEN-1));

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= IDLE;
      else        state_r <= next_state_s;
   end

   // Next state plus the issue/abort qualifiers; abort outranks pause and
   // the RUN->DRAIN move.
   always_comb begin
      next_state_s = state_r;
      issue_s      = 1'b0;
      abort_act_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) next_state_s = RUN;
            else       next_state_s = IDLE;
         end
         RUN: begin
            if (abort) begin
               abort_act_s  = 1'b1;
               next_state_s = IDLE;
            end else if (!pause) begin
               issue_s = 1'b1;
               if (ch_r == CH_W'(NUM_CH-1) && t_r == T_W'(SEG_LEN-1)) next_state_s = DRAIN;
               else                                                    next_state_s = RUN;
            end else begin
               next_state_s = RUN;
            end
         end
         DRAIN: begin
            if (abort) begin
               abort_act_s  = 1'b1;
               next_state_s = IDLE;
            end else if (final_wr_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = DRAIN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (next_state_s == RUN) || (next_state_s == DRAIN);
         done_r <= (next_state_s == DONE);
      end
   end

   // Read issue: registered strobe/address, ch/t walk, and the issue tag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch_r          <= '0;
         t_r           <= '0;
         out_rd_en_r   <= 1'b0;
         out_rd_addr_r <= '0;
         iss_first_r   <= 1'b0;
         iss_last_r    <= 1'b0;
         iss_t_r       <= '0;
      end else begin
         out_rd_en_r <= issue_s;
         if (issue_s) begin
            out_rd_addr_r <= rd_addr_s;
            iss_first_r   <= (ch_r == CH_W'(0));
            iss_last_r    <= (ch_r == CH_W'(NUM_CH-1));
            iss_t_r       <= t_r;
         end
         if (state_r == IDLE && start) begin
            ch_r <= '0;
            t_r  <= '0;
         end else if (issue_s) begin
            if (ch_r == CH_W'(NUM_CH-1)) begin
               ch_r <= '0;
               t_r  <= t_r + T_W'(1);
            end else begin
               ch_r <= ch_r + CH_W'(1);
            end
         end
      end
   end

   // The issue tag becomes valid with out_rd_en; the pipe adds RD_LAT more
   // cycles so its output matches out_rd_data.
   read_tag_pipe u_read_tag_pipe (
      .clk       (clk),
      .reset     (reset),
      .flush     (abort_act_s),
      .in_vld    (out_rd_en_r),
      .in_first  (iss_first_r),
      .in_last   (iss_last_r),
      .in_t      (iss_t_r),
      .out_vld   (tag_vld_s),
      .out_first (tag_first_s),
      .out_last  (tag_last_s),
      .out_t     (tag_t_s)
   );

   // Accumulator next value: first channel restarts the sum.
   always_comb begin
      acc_next_s = acc_r;
      if (tag_first_s) acc_next_s = sext_sample(out_rd_data);
      else             acc_next_s = acc_r + sext_sample(out_rd_data);
   end

   // Accumulate returning data and write the completed sum on the last channel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r         <= '0;
         sum_wr_en_r   <= 1'b0;
         sum_wr_addr_r <= '0;
         sum_wr_data_r <= '0;
      end else if (abort_act_s) begin
         sum_wr_en_r <= 1'b0;
      end else if (tag_vld_s) begin
         acc_r       <= acc_next_s;
         sum_wr_en_r <= tag_last_s;
         if (tag_last_s) begin
            sum_wr_addr_r <= tag_t_s;
            sum_wr_data_r <= acc_next_s;
         end
      end else begin
         sum_wr_en_r <= 1'b0;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign out_rd_en   = out_rd_en_r;
   assign out_rd_addr = out_rd_addr_r;
   assign sum_wr_en   = sum_wr_en_r;
   assign sum_wr_addr = sum_wr_addr_r;
   assign sum_wr_data = sum_wr_data_r;

endmodule

// File: tb/tb_beam_sum_sequencer.sv
// Scoreboard bench for beam_sum_sequencer: a RAM model feeds the DUT, the
// driver pushes expected sums computed from the RAM contents, and a monitor
// checks reads, writes and the done pulse as they appear.
module tb_beam_sum_sequencer;
   import beam_sum_sequencer_pkg::*;

   localparam int TOTAL    = NUM_CH * SEG_LEN;
   localparam int DONE_LAT = TOTAL + RD_LAT + 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              pause = 1'b0;
   logic              abort = 1'b0;
   logic              busy, done, out_rd_en, sum_wr_en;
   logic [ADDR_W-1:0] out_rd_addr;
   logic [DATA_W-1:0] out_rd_data = '0;
   logic [T_W-1:0]    sum_wr_addr;
   logic [SUM_W-1:0]  sum_wr_data;

   always #5 clk = ~clk;

   beam_sum_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
      .busy(busy), .done(done),
      .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
      .sum_wr_en(sum_wr_en), .sum_wr_addr(sum_wr_addr), .sum_wr_data(sum_wr_data)
   );

   logic [DATA_W-1:0] mem [TOTAL];

   // Output RAM model, one cycle of read latency.
   always @(posedge clk) if (out_rd_en) out_rd_data <= mem[out_rd_addr];

   typedef struct {int addr; logic [SUM_W-1:0] data;} wr_t;
   wr_t exp_q[$];

   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, start_cyc = 0, exp_done_cyc = -1, done_cnt = 0, rd_idx = 0;
   bit   done_seen = 1'b0;
   logic pause_q = 1'b0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      pause_q <= pause;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: read order, write contents, done timing.
   always @(negedge clk) begin
      if (reset) begin
         if (out_rd_en) begin
            check("rd_addr", 64'(out_rd_addr),
                  64'((rd_idx % NUM_CH) * SEG_LEN + rd_idx / NUM_CH));
            rd_idx++;
         end
         if (pause_q) check("no_read_while_paused", 64'(out_rd_en), 64'd0);
         if (sum_wr_en) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d data %0h, required no write", sum_wr_addr, sum_wr_data);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", 64'(sum_wr_addr), 64'(e.addr));
               check("wr_data", 64'(sum_wr_data), 64'(e.data));
            end
         end
         if (done) begin
            if (exp_done_cyc < 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
            end else begin
               check("done_cycle", 64'(cyc), 64'(exp_done_cyc));
            end
            done_cnt++;
            done_seen = 1'b1;
         end
      end
   end

   task automatic fill(input int kind);
      for (int c = 0; c < NUM_CH; c++)
         for (int t = 0; t < SEG_LEN; t++)
            case (kind)
               0:       mem[c*SEG_LEN+t] = 32'(c + 1);
               1:       mem[c*SEG_LEN+t] = 32'h7FFF_FFFF;
               2:       mem[c*SEG_LEN+t] = 32'h8000_0000;
               default: mem[c*SEG_LEN+t] = $urandom;
            endcase
   endtask

   task automatic push_expected(input int n_t);
      for (int t = 0; t < n_t; t++) begin
         longint s = 0;
         logic [63:0] tmp;
         wr_t e;
         for (int c = 0; c < NUM_CH; c++) s += longint'($signed(mem[c*SEG_LEN+t]));
         tmp    = s;
         e.addr = t;
         e.data = tmp[SUM_W-1:0];
         exp_q.push_back(e);
      end
   endtask

   task automatic start_pass();
      @(negedge clk);
      rd_idx    = 0;
      done_seen = 1'b0;
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done_seen && n < DONE_LAT + 100) begin
         @(negedge clk);
         n++;
      end
      check("pass_completed", 64'(done_seen), 64'd1);
      repeat (5) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("busy_low_after_pass", 64'(busy), 64'd0);
   endtask

   task automatic full_pass(input int kind, input bit pause_en, input bit extra_start);
      int d0;
      fill(kind);
      push_expected(SEG_LEN);
      d0 = done_cnt;
      start_pass();
      exp_done_cyc = start_cyc + DONE_LAT + (pause_en ? 10 : 0);
      check("busy_after_start", 64'(busy), 64'd1);
      if (pause_en) begin
         // RUN cycle start+1+k decides read k; k=803 is t=100, ch=3.
         wait_cycle(start_cyc + 1 + 100*NUM_CH + 3);
         pause = 1'b1;
         wait_cycle(start_cyc + 1 + 100*NUM_CH + 3 + 10);
         pause = 1'b0;
      end
      if (extra_start) begin
         wait_cycle(start_cyc + 2000);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
      check("one_done_per_pass", 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic abort_pass();
      int d0;
      fill(3);
      push_expected(5);
      exp_done_cyc = -1;
      d0 = done_cnt;
      start_pass();
      // Read for t=5, ch=7 (k=47) is on the bus in cycle start+49.
      wait_cycle(start_cyc + 49);
      check("abort_rd_en", 64'(out_rd_en), 64'd1);
      check("abort_rd_addr", 64'(out_rd_addr), 64'(7*SEG_LEN + 5));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("busy_after_abort", 64'(busy), 64'd0);
      check("rd_en_after_abort", 64'(out_rd_en), 64'd0);
      repeat (30) @(negedge clk);
      check("abort_writes", 64'(exp_q.size()), 64'd0);
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
   endtask

   task automatic reset_mid_pass();
      int n = 0;
      fill(3);
      push_expected(SEG_LEN);
      exp_done_cyc = -1;
      start_pass();
      while (!sum_wr_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wr_before_reset", 64'(sum_wr_en), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_rd_en", 64'(out_rd_en), 64'd0);
      check("rst_rd_addr", 64'(out_rd_addr), 64'd0);
      check("rst_wr_en", 64'(sum_wr_en), 64'd0);
      check("rst_wr_addr", 64'(sum_wr_addr), 64'd0);
      check("rst_wr_data", 64'(sum_wr_data), 64'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_after_reset", 64'(busy), 64'd0);
      check("no_reads_after_reset", 64'(out_rd_en), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("init_busy", 64'(busy), 64'd0);
      check("init_done", 64'(done), 64'd0);
      check("init_rd_en", 64'(out_rd_en), 64'd0);
      check("init_rd_addr", 64'(out_rd_addr), 64'd0);
      check("init_wr_en", 64'(sum_wr_en), 64'd0);
      check("init_wr_addr", 64'(sum_wr_addr), 64'd0);
      check("init_wr_data", 64'(sum_wr_data), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      full_pass(0, 1'b0, 1'b0);   // ch+1 pattern, sum 36
      full_pass(1, 1'b0, 1'b0);   // max positive
      full_pass(2, 1'b0, 1'b0);   // max negative
      full_pass(3, 1'b1, 1'b0);   // random with 10-cycle pause
      abort_pass();
      full_pass(3, 1'b0, 1'b0);   // recovery after abort
      full_pass(3, 1'b0, 1'b1);   // start while busy is ignored
      reset_mid_pass();
      full_pass(0, 1'b0, 1'b0);   // recovery after reset

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
